// File: rtl/tilt_axis_ctrl.sv
// tilt_axis_ctrl: single-axis gesture-to-command controller (two hand coordinates -> slew-limited command byte)
//   clock, reset      : system clock, synchronous active-high reset
//   enable            : 0 forces the target to NEUTRAL
//   snap              : 1 bypasses slew limiting (mag follows target every cycle)
//   frame_valid       : one-cycle strobe qualifying pos_a/pos_b
//   pos_a, pos_b      : hand coordinates, 0 = not detected
//   mag               : registered command value
//   direction         : 0 none, 1 positive, 2 negative
//   lost              : hands lost, target forced to NEUTRAL
//   settled           : mag equals target
module tilt_axis_ctrl #(
    parameter int COORD_W     = 16,
    parameter int OUT_W       = 8,
    parameter int NEUTRAL     = 116,
    parameter int DEAD        = 38,
    parameter int SAT         = 230,
    parameter int SHIFT       = 2,
    parameter int OUT_MIN     = 68,
    parameter int OUT_MAX     = 184,
    parameter int ZONE_MAX    = 511,
    parameter int LOST_FRAMES = 8,
    parameter int SLEW_DIV    = 50000,
    parameter int SLEW_STEP   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               snap,
    input  logic               frame_valid,
    input  logic [COORD_W-1:0] pos_a,
    input  logic [COORD_W-1:0] pos_b,
    output logic [OUT_W-1:0]   mag,
    output logic [1:0]         direction,
    output logic               lost,
    output logic               settled
);
    localparam int DW = COORD_W + 1;
    localparam int MW = $clog2(LOST_FRAMES + 1);
    localparam int CW = $clog2(SLEW_DIV + 1);
    localparam logic [OUT_W-1:0] NEU = OUT_W'(NEUTRAL);

    logic               cap_v, cap_ok;
    logic [COORD_W-1:0] cap_a, cap_b;
    logic [DW-1:0]      diff, raw, span;
    logic [OUT_W-1:0]   off, target, target_nxt, mag_nxt, gap, step;
    logic [1:0]         dir_nxt;
    logic [MW-1:0]      miss, miss_nxt;
    logic               lost_nxt, tick;
    logic [CW-1:0]      cnt;

    always_comb begin
        diff = cap_a > cap_b ? {1'b0, cap_a} - {1'b0, cap_b} : {1'b0, cap_b} - {1'b0, cap_a};
        span = cap_b > cap_a ? DW'(OUT_MAX - NEUTRAL) : DW'(NEUTRAL - OUT_MIN);
        // raw is only meaningful outside the deadband, where diff >= DEAD
        raw = (diff - DW'(DEAD)) >> SHIFT;
        off = (diff >= DW'(SAT) || raw > span) ? OUT_W'(span) : OUT_W'(raw);
        target_nxt = target;
        dir_nxt = direction;
        lost_nxt = lost;
        miss_nxt = miss;
        if (cap_v) begin
            if (cap_ok) begin
                miss_nxt = '0;
                lost_nxt = 1'b0;
                target_nxt = diff < DW'(DEAD) ? NEU : cap_b > cap_a ? NEU + off : NEU - off;
                dir_nxt = diff < DW'(DEAD) ? 2'd0 : cap_b > cap_a ? 2'd1 : 2'd2;
            end else begin
                miss_nxt = miss == MW'(LOST_FRAMES) ? miss : miss + 1'b1;
                if (miss_nxt == MW'(LOST_FRAMES)) begin
                    lost_nxt = 1'b1;
                    target_nxt = NEU;
                    dir_nxt = 2'd0;
                end
            end
        end
        // enable low overrides continuously, independent of frames
        if (!enable) begin
            target_nxt = NEU;
            dir_nxt = 2'd0;
        end
        tick = cnt == CW'(SLEW_DIV - 1);
        gap = target > mag ? target - mag : mag - target;
        step = gap > OUT_W'(SLEW_STEP) ? OUT_W'(SLEW_STEP) : gap;
        mag_nxt = snap ? target : !tick ? mag : target > mag ? mag + step : mag - step;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cap_v     <= 1'b0;
            cap_ok    <= 1'b0;
            cap_a     <= '0;
            cap_b     <= '0;
            target    <= NEU;
            direction <= 2'd0;
            lost      <= 1'b1;
            miss      <= MW'(LOST_FRAMES);
            cnt       <= '0;
            mag       <= NEU;
            settled   <= 1'b1;
        end else begin
            cap_v <= frame_valid;
            if (frame_valid) begin
                cap_a  <= pos_a;
                cap_b  <= pos_b;
                cap_ok <= pos_a != '0 && pos_b != '0 &&
                          pos_a <= COORD_W'(ZONE_MAX) && pos_b <= COORD_W'(ZONE_MAX);
            end
            target    <= target_nxt;
            direction <= dir_nxt;
            lost      <= lost_nxt;
            miss      <= miss_nxt;
            cnt       <= tick ? '0 : cnt + 1'b1;
            mag       <= mag_nxt;
            settled   <= mag_nxt == target_nxt;
        end
    end
endmodule

// File: tb/tb_tilt_axis_ctrl.sv
// tb_tilt_axis_ctrl: self-checking bench for tilt_axis_ctrl (vector table, corner sequences, random vs reference model)
module tb_tilt_axis_ctrl;
    localparam int NEU = 116, DEAD = 38, SAT = 230, SHIFT = 2, OMIN = 68, OMAX = 184;
    localparam int ZONE = 511, LOSTF = 8, DIV = 4, STEP = 2;

    logic        clock = 1'b0, reset = 1'b1, enable = 1'b1, snap = 1'b1, frame_valid = 1'b0;
    logic [15:0] pos_a = '0, pos_b = '0;
    logic [7:0]  mag;
    logic [1:0]  direction;
    logic        lost, settled;
    int          checks = 0, passes = 0;

    always #5 clock = ~clock;

    tilt_axis_ctrl #(.SLEW_DIV(DIV)) dut (
        .clock(clock), .reset(reset), .enable(enable), .snap(snap), .frame_valid(frame_valid),
        .pos_a(pos_a), .pos_b(pos_b), .mag(mag), .direction(direction), .lost(lost), .settled(settled)
    );

    typedef struct packed {
        int mag, tgt, dir, lst, stl, miss, cyc;
        bit pv, pok;
        int pa, pb;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t mrst();
        mstate_t n;
        n.mag = NEU; n.tgt = NEU; n.dir = 0; n.lst = 1; n.stl = 1; n.miss = LOSTF; n.cyc = 0;
        n.pv = 1'b0; n.pok = 1'b0; n.pa = 0; n.pb = 0;
        return n;
    endfunction

    function automatic void calc(input int a, input int b, output int t, output int d);
        int diff, span, off;
        diff = a > b ? a - b : b - a;
        span = b > a ? OMAX - NEU : NEU - OMIN;
        off = diff >= SAT ? span : (diff - DEAD) >>> SHIFT;
        if (off > span) off = span;
        if (diff < DEAD) begin
            t = NEU; d = 0;
        end else begin
            t = b > a ? NEU + off : NEU - off;
            d = b > a ? 1 : 2;
        end
    endfunction

    function automatic mstate_t mstep(mstate_t s, bit en, bit sn, bit fv, int a, int b);
        mstate_t n;
        int t, d, dm;
        n = s;
        n.cyc = s.cyc + 1;
        if (s.pv) begin
            if (s.pok) begin
                n.miss = 0; n.lst = 0;
                calc(s.pa, s.pb, t, d);
                n.tgt = t; n.dir = d;
            end else begin
                n.miss = s.miss + 1 > LOSTF ? LOSTF : s.miss + 1;
                if (n.miss == LOSTF) begin
                    n.lst = 1; n.tgt = NEU; n.dir = 0;
                end
            end
        end
        if (!en) begin
            n.tgt = NEU; n.dir = 0;
        end
        dm = s.tgt - s.mag;
        if (dm > STEP) dm = STEP;
        if (dm < -STEP) dm = -STEP;
        if (sn) n.mag = s.tgt;
        else if (n.cyc % DIV == 0) n.mag = s.mag + dm;
        n.stl = n.mag == n.tgt ? 1 : 0;
        n.pv = fv;
        n.pok = a != 0 && b != 0 && a <= ZONE && b <= ZONE;
        n.pa = a; n.pb = b;
        return n;
    endfunction

    always @(posedge clock)
        ms <= reset ? mrst() : mstep(ms, enable, snap, frame_valid, int'(pos_a), int'(pos_b));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic strobe(input int a, input int b);
        pos_a = 16'(a); pos_b = 16'(b); frame_valid = 1'b1;
        step(1);
        frame_valid = 1'b0;
    endtask

    function automatic int rc(input bit heavy);
        int r;
        r = $urandom_range(0, 9);
        if (heavy) return r < 7 ? (r < 3 ? 0 : int'($urandom_range(512, 700))) : int'($urandom_range(1, 511));
        return r == 0 ? 0 : r == 1 ? 600 : int'($urandom_range(1, 511));
    endfunction

    typedef struct {
        int a, b, m, d, l;
    } vec_t;

    vec_t vecs[14];
    int   la[7], lb[7];
    bit   heavy;

    initial begin
        vecs[0]  = '{200, 100, 101, 2, 0};
        vecs[1]  = '{50, 350, 184, 1, 0};
        vecs[2]  = '{100, 120, 116, 0, 0};
        vecs[3]  = '{300, 300, 116, 0, 0};
        vecs[4]  = '{100, 138, 116, 1, 0};
        vecs[5]  = '{100, 329, 163, 1, 0};
        vecs[6]  = '{100, 330, 184, 1, 0};
        vecs[7]  = '{330, 100, 68, 2, 0};
        vecs[8]  = '{329, 100, 69, 2, 0};
        vecs[9]  = '{500, 300, 76, 2, 0};
        vecs[10] = '{511, 1, 68, 2, 0};
        vecs[11] = '{512, 1, 68, 2, 0};
        vecs[12] = '{0, 50, 68, 2, 0};
        vecs[13] = '{120, 100, 116, 0, 0};
        la = '{200, 0, 600, 200, 512, 0, 200};
        lb = '{0, 100, 100, 600, 100, 0, 512};

        // reset values, with a strobe presented during reset that must be ignored
        pos_a = 16'd200; pos_b = 16'd100; frame_valid = 1'b1;
        step(3);
        check("rst_mag", int'(mag), NEU);
        check("rst_dir", int'(direction), 0);
        check("rst_lost", int'(lost), 1);
        check("rst_settled", int'(settled), 1);
        reset = 1'b0; frame_valid = 1'b0;
        step(3);
        check("rst_ignored_mag", int'(mag), NEU);
        check("rst_ignored_lost", int'(lost), 1);

        // vector table, snap mode
        foreach (vecs[i]) begin
            strobe(vecs[i].a, vecs[i].b);
            step(2);
            check($sformatf("vec%0d_mag", i), int'(mag), vecs[i].m);
            check($sformatf("vec%0d_dir", i), int'(direction), vecs[i].d);
            check($sformatf("vec%0d_lost", i), int'(lost), vecs[i].l);
            check($sformatf("vec%0d_settled", i), int'(settled), 1);
        end

        // slew down 116 -> 101, ticks every DIV edges counted from reset release
        reset = 1'b1; snap = 1'b0;
        step(2);
        reset = 1'b0; pos_a = 16'd200; pos_b = 16'd100; frame_valid = 1'b1;
        step(1);
        frame_valid = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            check($sformatf("slew_mag_k%0d", k), int'(mag), NEU - (2 * (k / 4) > 15 ? 15 : 2 * (k / 4)));
            check($sformatf("slew_settled_k%0d", k), int'(settled), (k < 2 || k >= 32) ? 1 : 0);
            if (k < 36) step(1);
        end
        // redirect upward, then reset mid-slew
        strobe(50, 350);
        step(11);
        check("slew_up_mag", int'(mag), 107);
        check("slew_up_settled", int'(settled), 0);
        reset = 1'b1;
        step(1);
        check("midslew_rst_mag", int'(mag), NEU);
        check("midslew_rst_lost", int'(lost), 1);
        check("midslew_rst_dir", int'(direction), 0);
        check("midslew_rst_settled", int'(settled), 1);
        reset = 1'b0; snap = 1'b1;

        // lost-frame counting, including out-of-zone coordinates
        strobe(200, 100);
        step(2);
        check("lost_pre_mag", int'(mag), 101);
        check("lost_pre_lost", int'(lost), 0);
        for (int i = 0; i < 7; i++) begin
            strobe(la[i], lb[i]);
            step(2);
            check($sformatf("miss%0d_mag", i + 1), int'(mag), 101);
            check($sformatf("miss%0d_lost", i + 1), int'(lost), 0);
            check($sformatf("miss%0d_dir", i + 1), int'(direction), 2);
        end
        strobe(600, 100);
        step(1);
        check("miss8_lost", int'(lost), 1);
        check("miss8_dir", int'(direction), 0);
        step(1);
        check("miss8_mag", int'(mag), NEU);
        strobe(200, 100);
        step(1);
        check("recover_lost", int'(lost), 0);
        check("recover_dir", int'(direction), 2);
        step(1);
        check("recover_mag", int'(mag), 101);

        // enable drop without any strobe
        strobe(100, 276);
        step(2);
        check("en_pre_mag", int'(mag), 150);
        check("en_pre_dir", int'(direction), 1);
        enable = 1'b0;
        step(1);
        check("en_off_dir", int'(direction), 0);
        step(1);
        check("en_off_mag", int'(mag), NEU);
        strobe(100, 276);
        step(2);
        check("en_off_frame_mag", int'(mag), NEU);
        check("en_off_frame_lost", int'(lost), 0);
        enable = 1'b1;
        step(3);
        check("en_back_mag", int'(mag), NEU);

        // back-to-back strobes alternating diff +100/-100
        for (int j = 0; j < 12; j++) begin
            frame_valid = j < 10;
            pos_a = j % 2 == 0 ? 16'd200 : 16'd100;
            pos_b = j % 2 == 0 ? 16'd100 : 16'd200;
            step(1);
            if (j >= 1 && j <= 10) check($sformatf("b2b_dir%0d", j - 1), int'(direction), (j - 1) % 2 == 0 ? 2 : 1);
            if (j >= 2) check($sformatf("b2b_mag%0d", j - 2), int'(mag), (j - 2) % 2 == 0 ? 101 : 131);
        end
        frame_valid = 1'b0;

        // randomized run against the reference model
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        heavy = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) heavy = $urandom_range(0, 2) == 0;
            if ($urandom_range(0, 150) == 0) snap = ~snap;
            if ($urandom_range(0, 80) == 0) enable = ~enable;
            reset = $urandom_range(0, 999) == 0;
            frame_valid = $urandom_range(0, 3) != 0;
            pos_a = 16'(rc(heavy));
            pos_b = 16'(rc(heavy));
            step(1);
            check("rnd_mag", int'(mag), ms.mag);
            check("rnd_dir", int'(direction), ms.dir);
            check("rnd_lost", int'(lost), ms.lst);
            check("rnd_settled", int'(settled), ms.stl);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/tilt_axis_ctrl.md
Name: tilt_axis_ctrl

Overview:
Parametrised single-axis gesture-to-command controller for the drone link.
- Takes two per-frame hand coordinates, e.g. left/right hand y for roll or upper/lower hand x for yaw.
- Derives a proportional command byte about a neutral value, with a deadband and saturation.
- Slew-limits the command and falls back to neutral when hands are lost for several frames.
- Sits between the hand-tracking centroid block and the PWM/serial command encoder; one instance per control axis.

Parameters:
COORD_W, 16, width of input coordinates
OUT_W, 8, width of command output
NEUTRAL, 116, command value for no motion
DEAD, 38, minimum |pos_a-pos_b| that produces motion
SAT, 230, difference at or above which the command saturates
SHIFT, 2, gain as a right shift applied to (diff-DEAD)
OUT_MIN, 68, saturated command value for the negative direction
OUT_MAX, 184, saturated command value for the positive direction
ZONE_MAX, 511, a coordinate above this is outside the active zone
LOST_FRAMES, 8, consecutive invalid frames before forcing neutral
SLEW_DIV, 50000, clock cycles per slew tick
SLEW_STEP, 2, maximum command change per slew tick

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  0 forces the target to NEUTRAL
snap  in  1  1 bypasses slew limiting
frame_valid  in  1  one-cycle strobe: pos_a/pos_b valid for a new frame
pos_a  in  COORD_W  first hand coordinate, 0 = not detected
pos_b  in  COORD_W  second hand coordinate, 0 = not detected
mag  out  OUT_W  registered command value
direction  out  2  0 none, 1 positive, 2 negative
lost  out  1  hands lost, target forced to neutral
settled  out  1  mag equals target

Behaviour:
Reset values:
- mag=NEUTRAL, target=NEUTRAL, direction=0, lost=1, settled=1.
- Miss counter = LOST_FRAMES (saturated); slew counter = 0.
- Strobes arriving during reset are ignored.

Stage 1 (capture), in the cycle after frame_valid:
- Register pos_a and pos_b, and the frame-ok flag.
- frame_ok = both coordinates nonzero AND both <= ZONE_MAX.

Stage 2 (target), one cycle after capture:
- diff = |pos_a - pos_b|, COORD_W+1 bits, never negative.
- If frame_ok: miss counter clears; lost is set to 0.
- If not frame_ok:
  - Miss counter increments, saturating at LOST_FRAMES.
  - When it reaches LOST_FRAMES: lost=1, target=NEUTRAL, direction=0.
  - Below LOST_FRAMES: target and direction hold their previous values.
- Target computation, when frame_ok and enable=1:
  - diff < DEAD: target=NEUTRAL, direction=0.
  - pos_b > pos_a: direction=1, target = NEUTRAL + off.
  - pos_a > pos_b: direction=2, target = NEUTRAL - off.
- off definition:
  - diff >= SAT: off = full span, i.e. OUT_MAX-NEUTRAL for direction 1 and NEUTRAL-OUT_MIN for direction 2.
  - Otherwise off = (diff-DEAD)>>SHIFT, clamped to the same span.
  - The target therefore always lies in [OUT_MIN, OUT_MAX].
- enable=0 overrides the target to NEUTRAL with direction=0 immediately, without waiting for a frame. The miss logic still runs.

Output stage:
- snap=1: mag <= target every cycle.
- snap=0:
  - A free-running slew counter produces a tick every SLEW_DIV cycles.
  - On each tick, mag moves toward target by min(SLEW_STEP, |target-mag|).
  - No overshoot; mag holds between ticks.
- Changing the target mid-slew redirects the slew from the current mag; the slew counter is not restarted.
- settled = (mag == target), registered alongside mag.

Latency:
- frame_valid at cycle N → target/direction/lost updated at N+2.
- In snap mode, mag is updated at N+3.

Other rules:
- Back-to-back strobes (every cycle) are supported; each is processed in order, fully pipelined.
- Equal coordinates give diff=0, which is treated as the deadband case.
- Reset mid-slew returns to the reset values on the next edge.

Test Plan:
- Reset, then strobe pos_a=200, pos_b=100, snap=1 → at N+2 direction=2, target=101 ((100-38)>>2=15); at N+3 mag=101, settled=1, lost=0.
- Strobe pos_a=50, pos_b=350, snap=1 → direction=1, mag=184 (saturated). Then pos_a=100, pos_b=120 (diff 20 < DEAD) → direction=0, mag=116.
- SLEW_DIV=4, snap=0, from mag=116 with target 101 → mag steps 114,112,…,102,101 at 4-cycle intervals (8 ticks); settled=0 until mag=101.
- After a valid frame with target 101: 7 strobes with pos_b=0 → target holds 101, lost=0. 8th strobe → lost=1, target=116, direction=0. One valid frame → lost=0.
- Strobe pos_a=600 (> ZONE_MAX) → counts as a miss. With target at 150, drop enable → target=116 without any strobe. Assert reset while mag=130 mid-slew → next cycle mag=116, lost=1.
- Strobes on 10 consecutive cycles with alternating diff 100/−100 (snap=1) → mag alternates 101/131 at a 3-cycle offset, no frame dropped.
